fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, instruction buffer entries and maximum in-flight plus buffered fetches.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 imem_req_valid  out  1  fetch request valid.
REQ-006 imem_req_ready  in  1  memory accepts request.
REQ-007 imem_req_addr  out  32  fetch byte address, bits [1:0] always 0.
REQ-008 imem_rsp_valid  in  1  returned word valid; responses arrive in request order, at least one cycle after acceptance.
REQ-009 imem_rsp_data  in  32  returned instruction word.
REQ-010 redirect_valid  in  1  branch/jump taken; restart fetch.
REQ-011 redirect_pc  in  32  new fetch address; bits [1:0] ignored and treated as 0.
REQ-012 instr_valid  out  1  instruction available to decoder.
REQ-013 instr_ready  in  1  decoder consumes instruction.
REQ-014 instruction  out  32  buffered instruction word at buffer head.
REQ-015 instr_pc  out  32  address of the word on instruction.

Function
REQ-016 A request is accepted in a cycle where imem_req_valid and imem_req_ready are both high; the fetch PC then advances by 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-017 imem_req_valid shall be high only when state is RUN, redirect_valid is low, and outstanding + buffer_count < DEPTH.
REQ-018 imem_req_valid and imem_req_addr shall stay stable while imem_req_ready is low, unless redirect_valid is asserted.
REQ-019 FSM states: BOOT (entered on reset, lasts exactly one cycle, no requests) -> RUN (remains there; redirect does not change state).
REQ-020 outstanding counter: +1 on acceptance, -1 on each response, both in the same cycle leave it unchanged; range 0..DEPTH.
REQ-021 Non-discarded responses push {rsp_pc, imem_rsp_data} into the buffer; rsp_pc starts at RESET_PC and advances by 4 per kept response.
REQ-022 instr_valid = buffer non-empty; pop when instr_valid and instr_ready; push and pop in the same cycle are legal, including when the buffer is full.
REQ-023 Latency: with imem_req_ready high and single-cycle memory, the first instr_valid occurs 3 cycles after rst deasserts (BOOT, request, response).
REQ-024 On redirect_valid: fetch PC <= redirect_pc, rsp_pc <= redirect_pc, buffer flushed (instr_valid low next cycle), drop_cnt <= outstanding - imem_rsp_valid.
REQ-025 A response arriving in the redirect cycle is discarded; while drop_cnt > 0 each response decrements drop_cnt and is discarded.
REQ-026 A pop coinciding with redirect counts as consumed; the flush still empties the buffer.
REQ-027 New requests after a redirect may issue while drop_cnt > 0, subject to REQ-017.

Reset
REQ-028 rst asserted asynchronously forces: state BOOT, fetch PC and rsp_pc = RESET_PC, outstanding = 0, drop_cnt = 0, buffer empty.
REQ-029 Outputs under reset: imem_req_valid 0, imem_req_addr RESET_PC, instr_valid 0, instruction 32'h0000_0013 (NOP), instr_pc RESET_PC.
REQ-030 Reset asserted mid-operation abandons in-flight fetches; the memory side is reset by the same rst.

Structure
REQ-031 Shared package riscv_pkg holds XLEN = 32, ILEN = 32, the NOP constant 32'h0000_0013 and the opcode constants used by the decoder.
REQ-032 Buffer is sub-module fetch_fifo: DEPTH-entry synchronous FIFO of 64-bit {pc, instr} with push, pop, flush, count, and first-word output.

Verification
REQ-033 Reset release, ready high, 1-cycle memory returning addr^32'hA5A5_0000 -> addresses 0, 4, 8 issued; first instr_valid at cycle 3 with instr_pc 0.
REQ-034 instr_ready low for 10 cycles -> exactly DEPTH = 2 requests issued, then imem_req_valid low; no response is lost; resumes in order.
REQ-035 Redirect to 32'h0000_0100 with 2 requests outstanding -> both stale responses dropped; the next instr_pc is 32'h100 with the matching word.
REQ-036 RESET_PC = 32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000 in order.
REQ-037 imem_req_ready held low 5 cycles -> imem_req_addr stable throughout; exactly one acceptance afterwards.
REQ-038 rst pulsed while 2 requests outstanding and the buffer is full -> all outputs at reset values immediately; clean restart from RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: ISA widths, the NOP encoding,
// major opcodes for the decoder, and the fetch buffer entry type.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  // addi x0, x0, 0
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic {
    FETCH_BOOT = 1'b0,
    FETCH_RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Fetch addresses are word aligned; low two bits are forced to zero.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH-entry synchronous FIFO of {pc, instr} with
// flush. Push while full is accepted only together with a pop.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     wr_entry,
  output fetch_entry_t     head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CAP = CNT_W'(DEPTH);

  fetch_entry_t mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic full;
  logic do_push;
  logic do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CAP);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the buffer in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until pointed to, so no reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches, tracks in-flight
// requests, buffers returned words and restarts cleanly on redirect by
// discarding responses to requests issued before the redirect.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instruction,
  output logic [XLEN-1:0] instr_pc
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] CAP = (CNT_W + 1)'(DEPTH);

  fetch_state_e     state;
  fetch_state_e     state_nxt;
  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  rsp_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] buf_count;
  logic [CNT_W:0]   in_use;
  logic             accept;
  logic             keep;
  logic             pop;
  logic             buf_empty;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;

  // Requests in flight plus words already buffered may never exceed DEPTH,
  // so every accepted request is guaranteed a buffer slot.
  assign in_use = {1'b0, outstanding} + {1'b0, buf_count};
  assign accept = imem_req_valid && imem_req_ready;
  assign keep   = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
  assign pop    = instr_valid && instr_ready;

  assign push_entry.pc    = rsp_pc;
  assign push_entry.instr = imem_rsp_data;

  // State register: BOOT for one cycle after reset, then RUN forever.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH_BOOT;
    else     state <= state_nxt;
  end

  // Next state and request qualification.
  always_comb begin
    state_nxt      = state;
    imem_req_valid = 1'b0;
    case (state)
      FETCH_BOOT: state_nxt = FETCH_RUN;
      FETCH_RUN:  imem_req_valid = !redirect_valid && (in_use < CAP);
    endcase
  end

  // Fetch PC: jumps on redirect, advances by one word per accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 fetch_pc <= RESET_PC;
    else if (redirect_valid) fetch_pc <= align_pc(redirect_pc);
    else if (accept)         fetch_pc <= fetch_pc + 32'd4;
  end

  // PC tagged onto the next kept response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 rsp_pc <= RESET_PC;
    else if (redirect_valid) rsp_pc <= align_pc(redirect_pc);
    else if (keep)           rsp_pc <= rsp_pc + 32'd4;
  end

  // In-flight request count; every response retires one, kept or not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({accept, imem_rsp_valid})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Stale responses still owed by memory after a redirect; a response in
  // the redirect cycle itself is discarded directly, hence the subtraction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     drop_cnt <= '0;
    else if (redirect_valid)                     drop_cnt <= outstanding - CNT_W'(imem_rsp_valid);
    else if (imem_rsp_valid && drop_cnt != '0)   drop_cnt <= drop_cnt - CNT_W'(1);
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (keep),
    .pop      (pop),
    .flush    (redirect_valid),
    .wr_entry (push_entry),
    .head     (head),
    .empty    (buf_empty),
    .count    (buf_count)
  );

  assign imem_req_addr = fetch_pc;
  assign instr_valid   = !buf_empty;
  assign instruction   = buf_empty ? NOP : head.instr;
  assign instr_pc      = buf_empty ? rsp_pc : head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit with an in-order memory
// model and a transaction-level reference of the fetch stream.
module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] WPC   = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, rsp_valid, redir, ivalid, iready;
  logic [31:0] req_addr, rsp_data, redir_pc, instr, ipc;

  logic        w_rst, w_req_valid, w_req_ready, w_rsp_valid, w_redir, w_ivalid, w_iready;
  logic [31:0] w_req_addr, w_rsp_data, w_redir_pc, w_instr, w_ipc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .redirect_valid(redir), .redirect_pc(redir_pc),
    .instr_valid(ivalid), .instr_ready(iready), .instruction(instr), .instr_pc(ipc)
  );

  fetch_unit #(.RESET_PC(WPC), .DEPTH(DEPTH)) dut_w (
    .clk(clk), .rst(w_rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .redirect_valid(w_redir), .redirect_pc(w_redir_pc),
    .instr_valid(w_ivalid), .instr_ready(w_iready), .instruction(w_instr), .instr_pc(w_ipc)
  );

  typedef struct { logic [31:0] addr; int due; bit stale; } flight_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } word_t;

  flight_t     memq[$];   // requests memory has accepted, oldest first
  word_t       bufq[$];   // words the decoder should see, oldest first
  logic [31:0] acc_log[$];
  logic [31:0] m_pc;
  bit          booted;
  int          cyc;
  int          first_iv_cyc;
  logic [31:0] first_iv_pc;
  int          total = 0;
  int          bad = 0;

  int rdy_pct, irdy_pct, rsp_pct, redir_pct, lat_lo, lat_hi;
  bit          force_redir = 1'b0;
  logic [31:0] force_pc = '0;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic knobs(input int r, input int ir, input int rs, input int rd,
                       input int lo, input int hi);
    rdy_pct = r; irdy_pct = ir; rsp_pct = rs; redir_pct = rd; lat_lo = lo; lat_hi = hi;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 32'(req_valid), 32'd0);
    check({tag, "_req_addr"}, req_addr, RPC);
    check({tag, "_instr_valid"}, 32'(ivalid), 32'd0);
    check({tag, "_instruction"}, instr, riscv_pkg::NOP);
    check({tag, "_instr_pc"}, ipc, RPC);
  endtask

  // Holds reset for two cycles, checks reset outputs, releases at a negedge.
  task automatic do_reset();
    rst = 1'b1;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    redir = 1'b0; redir_pc = '0; iready = 1'b0;
    memq.delete(); bufq.delete(); acc_log.delete();
    m_pc = RPC; booted = 1'b0; cyc = 0; first_iv_cyc = -1; first_iv_pc = '0;
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Asynchronous reset pulse in mid-cycle; outputs must react without a clock.
  task automatic mid_reset();
    #2 rst = 1'b1;
    rsp_valid = 1'b0;
    #1 check_reset_outputs("async_rst");
    do_reset();
  endtask

  // One clock: drive inputs at the negedge, compare, then advance the model.
  task automatic step();
    bit      exp_rv, acc, popd, rv_in;
    flight_t e;
    req_ready = ($urandom_range(99) < rdy_pct);
    iready    = ($urandom_range(99) < irdy_pct);
    redir     = force_redir ? 1'b1 : ($urandom_range(99) < redir_pct);
    redir_pc  = force_redir ? force_pc : $urandom();
    rsp_valid = 1'b0;
    rsp_data  = $urandom();
    if (memq.size() > 0 && memq[0].due <= cyc && $urandom_range(99) < rsp_pct) begin
      rsp_valid = 1'b1;
      rsp_data  = data_of(memq[0].addr);
    end
    #1;
    exp_rv = booted && !redir && (memq.size() + bufq.size() < DEPTH);
    check("req_valid", 32'(req_valid), 32'(exp_rv));
    check("req_addr", req_addr, m_pc);
    check("instr_valid", 32'(ivalid), 32'(bufq.size() > 0));
    if (bufq.size() > 0) begin
      check("instruction", instr, bufq[0].data);
      check("instr_pc", ipc, bufq[0].pc);
    end
    if (req_valid && req_ready) acc_log.push_back(req_addr);
    if (ivalid && first_iv_cyc < 0) begin
      first_iv_cyc = cyc;
      first_iv_pc  = ipc;
    end
    acc   = exp_rv && req_ready;
    popd  = (bufq.size() > 0) && iready;
    rv_in = rsp_valid;
    @(posedge clk);
    if (popd) void'(bufq.pop_front());
    if (rv_in) begin
      e = memq.pop_front();
      if (!redir && !e.stale) bufq.push_back('{pc: e.addr, data: data_of(e.addr)});
    end
    if (redir) begin
      foreach (memq[i]) memq[i].stale = 1'b1;
      bufq.delete();
      m_pc = {redir_pc[31:2], 2'b00};
    end else if (acc) begin
      memq.push_back('{addr: m_pc, due: cyc + $urandom_range(lat_hi, lat_lo), stale: 1'b0});
      m_pc = m_pc + 32'd4;
    end
    booted = 1'b1;
    cyc++;
    @(negedge clk);
  endtask

  // Second instance: reset PC near the top of the address space, 1-cycle memory.
  task automatic wrap_phase();
    logic [31:0] addrs[4];
    logic [31:0] pcs[3];
    int          na = 0, np = 0;
    bit          pend = 1'b0;
    logic [31:0] pend_addr = '0;
    logic [31:0] exp_a[4];
    exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC;
    exp_a[2] = 32'h0000_0000; exp_a[3] = 32'h0000_0004;
    foreach (addrs[i]) addrs[i] = 32'hDEAD_BEEF;
    foreach (pcs[i]) pcs[i] = 32'hDEAD_BEEF;
    @(negedge clk);
    w_rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      w_rsp_valid = pend;
      w_rsp_data  = data_of(pend_addr);
      #1;
      if (w_ivalid && np < 3) begin
        pcs[np] = w_ipc;
        check("wrap_instr", w_instr, data_of(w_ipc));
        np++;
      end
      pend      = w_req_valid && w_req_ready;
      pend_addr = w_req_addr;
      if (pend && na < 4) begin
        addrs[na] = w_req_addr;
        na++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    w_rst = 1'b1;
    w_rsp_valid = 1'b0;
    for (int i = 0; i < 4; i++) check("wrap_addr", addrs[i], exp_a[i]);
    for (int i = 0; i < 3; i++) check("wrap_pc", pcs[i], exp_a[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a0;
    int          n;
    w_rst = 1'b1; w_req_ready = 1'b1; w_rsp_valid = 1'b0; w_rsp_data = '0;
    w_redir = 1'b0; w_redir_pc = '0; w_iready = 1'b1;
    knobs(100, 100, 100, 0, 1, 1);

    // Startup latency and first addresses with single-cycle memory.
    do_reset();
    repeat (8) step();
    check("first_iv_cyc", 32'(first_iv_cyc), 32'd3);
    check("first_iv_pc", first_iv_pc, RPC);
    for (int i = 0; i < 3; i++)
      check("first_addr", (acc_log.size() > i) ? acc_log[i] : 32'hDEAD_BEEF, 32'(4 * i));

    // Decoder stalled: issue stops after DEPTH requests, then resumes in order.
    do_reset();
    knobs(100, 0, 100, 0, 1, 1);
    repeat (10) step();
    check("stall_accepts", 32'(acc_log.size()), 32'(DEPTH));
    check("stall_req_valid", 32'(req_valid), 32'd0);
    knobs(100, 100, 100, 0, 1, 1);
    repeat (10) step();

    // Memory not ready: address held, one acceptance once ready returns.
    do_reset();
    knobs(0, 100, 100, 0, 1, 1);
    a0 = req_addr;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_addr", req_addr, a0);
    end
    n = acc_log.size();
    knobs(100, 100, 100, 0, 1, 1);
    step();
    check("one_accept", 32'(acc_log.size() - n), 32'd1);
    repeat (6) step();

    // Redirect with two stale requests in flight.
    do_reset();
    knobs(100, 100, 100, 0, 3, 3);
    for (int i = 0; i < 20 && memq.size() < 2; i++) step();
    check("two_inflight", 32'(memq.size()), 32'd2);
    force_redir = 1'b1; force_pc = 32'h0000_0100;
    step();
    force_redir = 1'b0;
    for (int i = 0; i < 20 && !ivalid; i++) step();
    check("redir_valid", 32'(ivalid), 32'd1);
    check("redir_pc", ipc, 32'h0000_0100);
    check("redir_word", instr, data_of(32'h0000_0100));
    repeat (6) step();

    // Async reset with a full buffer, then with requests in flight.
    do_reset();
    knobs(100, 0, 100, 0, 1, 1);
    repeat (8) step();
    check("full_before_rst", 32'(ivalid), 32'd1);
    mid_reset();
    knobs(100, 100, 100, 0, 1, 1);
    repeat (10) step();
    check("restart_addr", (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_BEEF, RPC);
    knobs(100, 100, 100, 0, 5, 5);
    repeat (4) step();
    mid_reset();
    knobs(100, 100, 100, 0, 1, 2);
    repeat (10) step();

    // Randomized traffic including redirects and occasional resets.
    for (int r = 0; r < 6; r++) begin
      knobs(40 + $urandom_range(60), 40 + $urandom_range(60), 50 + $urandom_range(50),
            $urandom_range(8), 1, 1 + $urandom_range(3));
      repeat (500) step();
      mid_reset();
    end

    wrap_phase();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
